// File: rtl/avg_pool_pkg.sv
// Shared types and default widths for the global average-pool front end.
// Contents:
//   state_t         - sequencing states of avg_pool_accum
//   DEF_DATA_WIDTH  - default signed activation width
//   DEF_ACC_WIDTH   - default accumulator / divider operand width
package avg_pool_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ACC_WIDTH  = 32;

    typedef enum logic [1:0] {
        ACCUM,
        ISSUE,
        WAIT_DIV,
        OUTPUT
    } state_t;

endpackage

// File: rtl/avg_pool_accum_if.sv
// Bundles the three handshake groups of avg_pool_accum: input activation stream,
// divider request/response, and averaged output stream.
// Modports:
//   slave  - the pooling block itself
//   master - the surrounding environment (producer, divider, consumer)
interface avg_pool_accum_if
    import avg_pool_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int CHANNELS   = 8
) ();
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    // Input activation stream, HWC order (channel fastest)
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_data;

    // Divider request / response
    logic                         div_valid_in;
    logic signed [ACC_WIDTH-1:0]  div_dividend;
    logic signed [ACC_WIDTH-1:0]  div_divisor;
    logic signed [ACC_WIDTH-1:0]  div_quotient;
    logic                         div_valid_out;
    logic                         div_overflow;

    // Averaged output stream
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic [CH_W-1:0]              out_channel;
    logic                         out_last;

    modport slave (
        input  in_valid, in_data, div_quotient, div_valid_out, div_overflow, out_ready,
        output in_ready, div_valid_in, div_dividend, div_divisor,
        output out_valid, out_data, out_channel, out_last
    );

    modport master (
        output in_valid, in_data, div_quotient, div_valid_out, div_overflow, out_ready,
        input  in_ready, div_valid_in, div_dividend, div_divisor,
        input  out_valid, out_data, out_channel, out_last
    );

endinterface

// File: rtl/avg_pool_sat.sv
// Combinational signed clamp from ACC_WIDTH down to DATA_WIDTH.
// Ports:
//   value   in  ACC_WIDTH   signed input
//   result  out DATA_WIDTH  value clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]
//   clamped out 1           high when value lay outside that range
module avg_pool_sat
    import avg_pool_pkg::*;
#(
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic signed [ACC_WIDTH-1:0]  value,
    output logic signed [DATA_WIDTH-1:0] result,
    output logic                         clamped
);
    // The value fits iff every bit from the result sign bit upward equals the sign.
    logic [ACC_WIDTH-DATA_WIDTH:0] top_bits;

    assign top_bits = value[ACC_WIDTH-1:DATA_WIDTH-1];

    always_comb begin
        clamped = !((&top_bits) || !(|top_bits));
        result  = value[DATA_WIDTH-1:0];
        if (clamped) begin
            result = value[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                        : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/avg_pool_accum.sv
// Global average-pool front end. Sums a channel-interleaved window of activations
// into one accumulator per channel, then divides each sum by WINDOW_SIZE using an
// external divider, one channel at a time, and streams out the clamped averages.
// Ports:
//   clk    in   clock
//   reset  in   asynchronous, active-high reset
//   bus    slave modport: in_* stream, div_* divider handshake, out_* stream
//   err    out  sticky: divider overflow seen or an average was clamped
module avg_pool_accum
    import avg_pool_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int CHANNELS    = 8,
    parameter int WINDOW_SIZE = 49,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH
) (
    input  logic            clk,
    input  logic            reset,
    avg_pool_accum_if.slave bus,
    output logic            err
);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PIX_W = (WINDOW_SIZE > 1) ? $clog2(WINDOW_SIZE) : 1;

    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CHANNELS - 1);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(WINDOW_SIZE - 1);

    // A full window of extreme samples must not wrap the accumulator.
    if (ACC_WIDTH < DATA_WIDTH + $clog2(WINDOW_SIZE)) begin : g_acc_width_check
        $error("avg_pool_accum: ACC_WIDTH too narrow for DATA_WIDTH and WINDOW_SIZE");
    end
    if (WINDOW_SIZE < 1 || CHANNELS < 1) begin : g_size_check
        $error("avg_pool_accum: WINDOW_SIZE and CHANNELS must be at least 1");
    end

    state_t                       state_q, state_d;
    logic [CH_W-1:0]              ch_q, ch_d;
    logic [PIX_W-1:0]             pix_q, pix_d;
    logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                         err_q, err_d;
    logic signed [ACC_WIDTH-1:0]  acc_q [CHANNELS];

    logic                         in_fire;
    logic                         last_ch;
    logic                         last_pix;
    logic signed [ACC_WIDTH-1:0]  in_ext;
    logic signed [ACC_WIDTH-1:0]  cur_acc;
    logic signed [DATA_WIDTH-1:0] sat_value;
    logic                         sat_clamped;

    assign in_fire  = bus.in_valid && (state_q == ACCUM);
    assign last_ch  = (ch_q == LAST_CH);
    assign last_pix = (pix_q == LAST_PIX);
    assign in_ext   = ACC_WIDTH'(bus.in_data);
    assign cur_acc  = acc_q[ch_q];

    avg_pool_sat #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sat (
        .value   (bus.div_quotient),
        .result  (sat_value),
        .clamped (sat_clamped)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ACCUM;
            ch_q       <= '0;
            pix_q      <= '0;
            out_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            pix_q      <= pix_d;
            out_data_q <= out_data_d;
            err_q      <= err_d;
        end
    end

    // First pixel of a window overwrites, so no clear pass is needed between windows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= '0;
            end
        end else if (in_fire) begin
            acc_q[ch_q] <= (pix_q == '0) ? in_ext : cur_acc + in_ext;
        end
    end

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        pix_d      = pix_q;
        out_data_d = out_data_q;
        err_d      = err_q;

        unique case (state_q)
            ACCUM: begin
                if (in_fire) begin
                    if (last_ch) begin
                        ch_d = '0;
                        if (last_pix) begin
                            state_d = ISSUE;
                        end else begin
                            pix_d = pix_q + PIX_W'(1);
                        end
                    end else begin
                        ch_d = ch_q + CH_W'(1);
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT_DIV;
            end
            WAIT_DIV: begin
                if (bus.div_valid_out) begin
                    out_data_d = sat_value;
                    err_d      = err_q || sat_clamped || bus.div_overflow;
                    state_d    = OUTPUT;
                end
            end
            OUTPUT: begin
                if (bus.out_ready) begin
                    if (last_ch) begin
                        ch_d    = '0;
                        pix_d   = '0;
                        state_d = ACCUM;
                    end else begin
                        ch_d    = ch_q + CH_W'(1);
                        state_d = ISSUE;
                    end
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    assign bus.in_ready     = (state_q == ACCUM);
    assign bus.div_valid_in = (state_q == ISSUE);
    // Operand is held for the whole request since neither acc nor ch move until OUTPUT.
    assign bus.div_dividend = (state_q == ISSUE || state_q == WAIT_DIV) ? cur_acc : '0;
    assign bus.div_divisor  = ACC_WIDTH'(WINDOW_SIZE);
    assign bus.out_valid    = (state_q == OUTPUT);
    assign bus.out_data     = out_data_q;
    assign bus.out_channel  = (state_q == OUTPUT) ? ch_q : '0;
    assign bus.out_last     = (state_q == OUTPUT) && last_ch;
    assign err              = err_q;

endmodule

// File: doc/avg_pool_accum.md
# avg_pool_accum

Front end of the global average-pool layer. Consumes a channel-interleaved activation stream for one spatial window, keeps one running sum per channel, then issues one division per channel to the existing `div` divider (divisor = window size). It returns the saturated per-channel averages on a ready/valid output stream to the next layer.

## Interface

Parameters:
- DATA_WIDTH, 16, signed activation width (input and output)
- CHANNELS, 8, channels per pixel
- WINDOW_SIZE, 49, pixels per pooling window (≥1)
- ACC_WIDTH, 32, accumulator and divider operand width

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts input sample
- in_data  in  DATA_WIDTH  signed activation, HWC order (channel fastest)
- div_valid_in  out  1  one-cycle divide request pulse
- div_dividend  out  ACC_WIDTH  channel sum, sign-extended
- div_divisor  out  ACC_WIDTH  constant WINDOW_SIZE
- div_quotient  in  ACC_WIDTH  divider quotient (signed, truncated toward zero)
- div_valid_out  in  1  divider result strobe
- div_overflow  in  1  divider divide-by-zero flag
- out_valid  out  1  average valid
- out_ready  in  1  downstream accepts average
- out_data  out  DATA_WIDTH  saturated average
- out_channel  out  $clog2(CHANNELS)  channel index of out_data
- out_last  out  1  high with the final channel of a window
- err  out  1  sticky: div_overflow seen or saturation occurred

## Operation

- States: ACCUM, ISSUE, WAIT_DIV, OUTPUT. Reset state is ACCUM.
- ACCUM:
  - in_ready=1. On in_valid&&in_ready, acc[ch] gets the sign-extended in_data if pix==0, else acc[ch]+in_data. No separate clear pass.
  - ch wraps at CHANNELS-1; pix increments when ch wraps.
  - The handshake with pix==WINDOW_SIZE-1 and ch==CHANNELS-1 sets ch=0 and goes to ISSUE.
- ISSUE:
  - in_ready=0. Drive div_valid_in=1 for exactly one cycle, with div_dividend=acc[ch] and div_divisor=WINDOW_SIZE. Go to WAIT_DIV.
- WAIT_DIV:
  - div_dividend and div_divisor are held stable until div_valid_out.
  - On div_valid_out, register clamp(div_quotient) into out_data and go to OUTPUT.
  - div_overflow sampled high with div_valid_out sets err.
- OUTPUT:
  - out_valid=1; out_channel=ch; out_last=(ch==CHANNELS-1).
  - On out_ready with out_last: clear pix and ch, go to ACCUM.
  - On out_ready otherwise: ch++, go to ISSUE.
- Arithmetic:
  - Sums are in two's complement at ACC_WIDTH. Configurations must satisfy ACC_WIDTH ≥ DATA_WIDTH+$clog2(WINDOW_SIZE); this is checked by an elaboration assertion.
  - Clamp range is [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Clamping sets err.
- The input stream stays stalled (in_ready=0) from ISSUE until the last channel's output handshake. Windows are never overlapped.

## Timing

- Reset values:
  - in_ready=1 (state ACCUM), with inputs ignored while reset is high.
  - All other outputs 0: div_valid_in, div_dividend, out_valid, out_data, out_channel, out_last, err.
  - div_divisor is constant WINDOW_SIZE.
  - Counters and accumulators reset to 0.
- Input throughput: one sample per cycle in ACCUM.
- Per channel: ISSUE (1 cycle) + divider latency L + 1 register cycle until out_valid, + ≥1 OUTPUT cycle.
- out_data, out_channel and out_last are held stable while out_valid && !out_ready.
- div_valid_out outside WAIT_DIV is ignored.
- A reset mid-window or mid-divide returns the block to ACCUM with pix=ch=0. The divider shares the reset, so no stale result is consumed.
- err clears only on reset.

## Structure

- Package avg_pool_pkg:
  - state_t enum {ACCUM, ISSUE, WAIT_DIV, OUTPUT}
  - shared default widths (ACC_WIDTH=32, DATA_WIDTH=16), also used by the divider instance.
- Sub-module avg_pool_sat: combinational ACC_WIDTH→DATA_WIDTH signed clamp with an overflow flag.
- The accumulator array is a register vector of CHANNELS entries; no RAM.

## Test plan

- WINDOW_SIZE=4, CHANNELS=2, c0={4,8,12,16}, c1={-4,-8,-12,-16} -> outputs (ch0,10), (ch1,-10,out_last=1); err=0.
- Truncation: c0={1,2,2,2}, c1={-1,-2,-2,-2} -> 1 and -1 (toward zero).
- Backpressure: out_ready low for 5 cycles during ch0 output -> out_data held, no div_valid_in pulse and in_ready=0 throughout; ch1 issued 1 cycle after release.
- Back-to-back windows: window 1 all 100, window 2 all 2 -> second results are 2 (no stale sum).
- DATA_WIDTH=8: all samples 127 then sum clamp check with forced div_quotient=300 -> out_data=127, err=1.
- Reset asserted 2 cycles into WAIT_DIV -> all outputs at reset values; a fresh window yields correct averages; div_overflow forced with div_valid_out -> err=1.
